// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of a UART transmitter; a small drain FSM hands one byte
// at a time downstream and paces itself on the transmitter's busy signal.
module uart_tx_fifo #(
    parameter int DEPTH    = 16,
    parameter int CNT_BITS = $clog2(DEPTH) + 1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_wr,
    input  logic [7:0]          i_data,
    output logic                o_full,
    output logic                o_empty,
    output logic [CNT_BITS-1:0] o_count,
    output logic                o_overflow,
    input  logic                i_busy,
    output logic                o_wr,
    output logic [7:0]          o_data
);
    // state   | meaning
    // IDLE    | waiting for a stored byte and an idle transmitter
    // SEND    | o_wr asserted for exactly one cycle
    // WAIT_HI | waiting for the transmitter to report busy
    // WAIT_LO | waiting for the transmitter to finish the byte
    typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_t;

    localparam int PTR_BITS = CNT_BITS - 1;
    localparam logic [CNT_BITS-1:0] CNT_FULL = CNT_BITS'(DEPTH);
    localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);
    localparam logic [PTR_BITS-1:0] PTR_ONE  = PTR_BITS'(1);

    state_t              state;
    logic [7:0]          mem [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr;
    logic [PTR_BITS-1:0] rd_ptr;
    logic [CNT_BITS-1:0] count;
    logic                push;
    logic                pop;

    assign o_count = count;
    assign o_full  = (count == CNT_FULL);
    assign o_empty = (count == '0);
    // Full status from before the edge governs, so a pop never frees room for a same-cycle write.
    assign push    = i_wr && !o_full;
    assign pop     = (state == IDLE) && !o_empty && !i_busy;

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_overflow <= 1'b0;
        end else begin
            o_overflow <= i_wr && o_full;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= IDLE;
            o_wr   <= 1'b0;
            o_data <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        o_data <= mem[rd_ptr];
                        o_wr   <= 1'b1;
                        state  <= SEND;
                    end
                end
                SEND: begin
                    o_wr  <= 1'b0;
                    state <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (i_busy) begin
                        state <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (!i_busy) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    o_wr  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a busy responder model and a negedge monitor
// that records every byte handed to the transmitter.
module tb_uart_tx_fifo;
    localparam int DEPTH    = 16;
    localparam int CNT_BITS = 5;

    logic                i_clk = 1'b0;
    logic                i_rst_n = 1'b1;
    logic                i_wr = 1'b0;
    logic [7:0]          i_data = 8'h00;
    logic                i_busy;
    logic                o_full;
    logic                o_empty;
    logic [CNT_BITS-1:0] o_count;
    logic                o_overflow;
    logic                o_wr;
    logic [7:0]          o_data;

    int errors = 0;
    int checks = 0;

    logic auto_busy = 1'b0;
    logic man_busy = 1'b0;
    logic model_busy = 1'b0;
    int   busy_len = 100;
    int   dly = 0;
    int   hold = 0;

    int         tx_cnt = 0;
    logic [7:0] tx_q[$];
    logic       prev_wr = 1'b0;
    logic       prev_busy = 1'b0;
    logic       fell = 1'b0;

    assign i_busy = auto_busy ? model_busy : man_busy;

    uart_tx_fifo #(.DEPTH(DEPTH), .CNT_BITS(CNT_BITS)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_wr(i_wr), .i_data(i_data),
        .o_full(o_full), .o_empty(o_empty), .o_count(o_count), .o_overflow(o_overflow),
        .i_busy(i_busy), .o_wr(o_wr), .o_data(o_data)
    );

    always #5 i_clk = ~i_clk;

    // Monitor first, then advance the transmitter model, all on the negedge.
    always @(negedge i_clk) begin
        if (o_wr === 1'b1) begin
            checks++;
            if (prev_wr !== 1'b0) begin
                errors++;
                $display("FAIL wr_width: o_wr high on two consecutive cycles, prev=%b required 0", prev_wr);
            end
            if (auto_busy && tx_cnt > 0) begin
                checks++;
                if (fell !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_order: o_wr pulse %0d before i_busy fell, fell=%b required 1", tx_cnt, fell);
                end
            end
            tx_q.push_back(o_data);
            tx_cnt++;
            fell = 1'b0;
        end
        if (prev_busy && !i_busy) fell = 1'b1;
        prev_wr   = o_wr;
        prev_busy = i_busy;
        if (!auto_busy) begin
            model_busy = 1'b0;
            dly = 0;
            hold = 0;
        end else if (o_wr === 1'b1) begin
            dly = 2;
        end else if (dly > 0) begin
            dly--;
            if (dly == 0) begin
                model_busy = 1'b1;
                hold = busy_len;
            end
        end else if (hold > 0) begin
            hold--;
            if (hold == 0) model_busy = 1'b0;
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic tx_clear();
        tx_q.delete();
        tx_cnt = 0;
        fell = 1'b0;
    endtask

    task automatic do_reset();
        i_wr = 1'b0;
        i_data = 8'h00;
        auto_busy = 1'b0;
        man_busy = 1'b0;
        @(posedge i_clk);
        #3 i_rst_n = 1'b0;
        repeat (2) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        tick();
        tx_clear();
    endtask

    task automatic write_byte(input logic [7:0] b);
        i_wr = 1'b1;
        i_data = b;
        tick();
        i_wr = 1'b0;
    endtask

    task automatic wait_tx(input int n, input int budget, input string name);
        int w = 0;
        while (tx_cnt < n && w < budget) begin
            tick();
            w++;
        end
        checks++;
        if (tx_cnt < n) begin
            errors++;
            $display("FAIL %s_timeout: got %0d bytes, required %0d", name, tx_cnt, n);
        end
    endtask

    task automatic test_reset();
        #3 i_rst_n = 1'b0;
        #1;
        checks += 6;
        if (o_empty !== 1'b1)    begin errors++; $display("FAIL rst_empty: got %b required 1", o_empty); end
        if (o_full !== 1'b0)     begin errors++; $display("FAIL rst_full: got %b required 0", o_full); end
        if (o_count !== 5'd0)    begin errors++; $display("FAIL rst_count: got %0d required 0", o_count); end
        if (o_overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %b required 0", o_overflow); end
        if (o_wr !== 1'b0)       begin errors++; $display("FAIL rst_wr: got %b required 0", o_wr); end
        if (o_data !== 8'h00)    begin errors++; $display("FAIL rst_data: got %h required 00", o_data); end
        repeat (2) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        do_reset();
        write_byte(8'hA5);
        checks += 2;
        if (o_count !== 5'd1) begin errors++; $display("FAIL single_count1: got %0d required 1", o_count); end
        if (o_wr !== 1'b0)    begin errors++; $display("FAIL single_wr_early: got %b required 0", o_wr); end
        tick();
        checks += 3;
        if (o_wr !== 1'b1)    begin errors++; $display("FAIL single_wr: got %b required 1", o_wr); end
        if (o_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %h required a5", o_data); end
        if (o_count !== 5'd0) begin errors++; $display("FAIL single_count0: got %0d required 0", o_count); end
        tick();
        checks += 3;
        if (o_wr !== 1'b0)    begin errors++; $display("FAIL single_wr_clear: got %b required 0", o_wr); end
        if (o_data !== 8'hA5) begin errors++; $display("FAIL single_data_hold: got %h required a5", o_data); end
        if (tx_cnt !== 1)     begin errors++; $display("FAIL single_pulses: got %0d required 1", tx_cnt); end
    endtask

    task automatic test_handshake();
        do_reset();
        auto_busy = 1'b1;
        busy_len = 100;
        write_byte(8'h01);
        write_byte(8'h02);
        write_byte(8'h03);
        wait_tx(3, 600, "handshake");
        repeat (150) tick();
        checks += 2;
        if (tx_cnt !== 3)      begin errors++; $display("FAIL hs_pulses: got %0d required 3", tx_cnt); end
        if (o_empty !== 1'b1)  begin errors++; $display("FAIL hs_empty: got %b required 1", o_empty); end
        for (int i = 0; i < 3 && i < tx_q.size(); i++) begin
            checks++;
            if (tx_q[i] !== 8'(i + 1)) begin
                errors++;
                $display("FAIL hs_data[%0d]: got %h required %h", i, tx_q[i], 8'(i + 1));
            end
        end
        auto_busy = 1'b0;
    endtask

    task automatic test_full();
        do_reset();
        man_busy = 1'b1;
        for (int i = 0; i < DEPTH; i++) write_byte(8'(8'h10 + i));
        checks += 3;
        if (o_full !== 1'b1)     begin errors++; $display("FAIL full_flag: got %b required 1", o_full); end
        if (o_count !== 5'd16)   begin errors++; $display("FAIL full_count: got %0d required 16", o_count); end
        if (o_overflow !== 1'b0) begin errors++; $display("FAIL full_ovf_early: got %b required 0", o_overflow); end
        write_byte(8'h20);
        checks += 2;
        if (o_overflow !== 1'b1) begin errors++; $display("FAIL full_ovf: got %b required 1", o_overflow); end
        if (o_count !== 5'd16)   begin errors++; $display("FAIL full_count_kept: got %0d required 16", o_count); end
        tick();
        checks++;
        if (o_overflow !== 1'b0) begin errors++; $display("FAIL full_ovf_width: got %b required 0", o_overflow); end
        busy_len = 3;
        auto_busy = 1'b1;
        wait_tx(DEPTH, 400, "full_drain");
        repeat (30) tick();
        checks += 2;
        if (tx_cnt !== DEPTH) begin errors++; $display("FAIL full_drain_cnt: got %0d required %0d", tx_cnt, DEPTH); end
        if (o_empty !== 1'b1) begin errors++; $display("FAIL full_drain_empty: got %b required 1", o_empty); end
        for (int i = 0; i < DEPTH && i < tx_q.size(); i++) begin
            checks++;
            if (tx_q[i] !== 8'(8'h10 + i)) begin
                errors++;
                $display("FAIL full_data[%0d]: got %h required %h", i, tx_q[i], 8'(8'h10 + i));
            end
        end
        auto_busy = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        busy_len = 3;
        auto_busy = 1'b1;
        for (int i = 0; i < 3 * DEPTH; i++) begin
            int w = 0;
            while (o_full && w < 200) begin
                tick();
                w++;
            end
            if (o_full) begin
                checks++;
                errors++;
                $display("FAIL wrap_full_timeout: o_full=%b required 0 at byte %0d", o_full, i);
            end
            write_byte(8'(i));
        end
        wait_tx(3 * DEPTH, 2000, "wrap");
        repeat (20) tick();
        checks += 2;
        if (tx_cnt !== 3 * DEPTH) begin errors++; $display("FAIL wrap_cnt: got %0d required %0d", tx_cnt, 3 * DEPTH); end
        if (o_empty !== 1'b1)     begin errors++; $display("FAIL wrap_empty: got %b required 1", o_empty); end
        for (int i = 0; i < 3 * DEPTH && i < tx_q.size(); i++) begin
            checks++;
            if (tx_q[i] !== 8'(i)) begin
                errors++;
                $display("FAIL wrap_data[%0d]: got %h required %h", i, tx_q[i], 8'(i));
            end
        end
        auto_busy = 1'b0;
    endtask

    task automatic test_simul();
        do_reset();
        man_busy = 1'b1;
        for (int i = 0; i < DEPTH; i++) write_byte(8'(8'h40 + i));
        checks++;
        if (o_count !== 5'd16) begin errors++; $display("FAIL simul_fill: got %0d required 16", o_count); end
        man_busy = 1'b0;
        i_wr = 1'b1;
        i_data = 8'hEE;
        tick();
        i_wr = 1'b0;
        checks += 5;
        if (o_overflow !== 1'b1) begin errors++; $display("FAIL simul_ovf: got %b required 1", o_overflow); end
        if (o_count !== 5'd15)   begin errors++; $display("FAIL simul_count: got %0d required 15", o_count); end
        if (o_wr !== 1'b1)       begin errors++; $display("FAIL simul_wr: got %b required 1", o_wr); end
        if (o_data !== 8'h40)    begin errors++; $display("FAIL simul_data: got %h required 40", o_data); end
        if (o_full !== 1'b0)     begin errors++; $display("FAIL simul_full: got %b required 0", o_full); end
        tick();
        checks++;
        if (o_overflow !== 1'b0) begin errors++; $display("FAIL simul_ovf_width: got %b required 0", o_overflow); end
    endtask

    task automatic test_reset_mid();
        int n0;
        do_reset();
        for (int i = 0; i < 6; i++) write_byte(8'(8'h31 + i));
        checks += 2;
        if (o_count !== 5'd5) begin errors++; $display("FAIL rmid_count: got %0d required 5", o_count); end
        if (tx_cnt !== 1)     begin errors++; $display("FAIL rmid_first: got %0d required 1", tx_cnt); end
        man_busy = 1'b1;
        tick();
        tick();
        #2 i_rst_n = 1'b0;
        #1;
        checks += 5;
        if (o_wr !== 1'b0)    begin errors++; $display("FAIL rmid_wr: got %b required 0", o_wr); end
        if (o_count !== 5'd0) begin errors++; $display("FAIL rmid_count0: got %0d required 0", o_count); end
        if (o_empty !== 1'b1) begin errors++; $display("FAIL rmid_empty: got %b required 1", o_empty); end
        if (o_full !== 1'b0)  begin errors++; $display("FAIL rmid_full: got %b required 0", o_full); end
        if (o_data !== 8'h00) begin errors++; $display("FAIL rmid_data: got %h required 00", o_data); end
        man_busy = 1'b0;
        repeat (2) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        n0 = tx_cnt;
        repeat (50) tick();
        checks += 2;
        if (tx_cnt !== n0)    begin errors++; $display("FAIL rmid_stale: got %0d pulses required 0", tx_cnt - n0); end
        if (o_empty !== 1'b1) begin errors++; $display("FAIL rmid_empty_after: got %b required 1", o_empty); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_handshake();
        test_full();
        test_wrap();
        test_simul();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
